// File: rtl/fround_arbiter_if.sv
// rtl/fround_arbiter_if.sv - request/result bundle for the shared FRound arbiter
interface fround_arbiter_if #(
  parameter int n_req = 3,
  parameter int n_int = 32,
  parameter int n_exp = 8,
  parameter int n_sig = 23,
  parameter int id_w  = (n_req > 1) ? $clog2(n_req) : 1
);
  logic [n_req-1:0]       req_valid;
  logic [n_req-1:0]       req_ready;
  logic [n_req-1:0]       req_sign;
  logic [n_req*n_int-1:0] req_sig;
  logic [n_req*n_exp-1:0] req_exp;
  logic [n_req*3-1:0]     req_rm;
  logic [2:0]             frm;
  logic                   res_valid;
  logic                   res_ready;
  logic [id_w-1:0]        res_id;
  logic                   res_sign;
  logic [n_sig-1:0]       res_sig;
  logic [n_exp-1:0]       res_exp;
  logic                   res_nx;
  logic                   res_of;

  modport master (
    output req_valid, req_sign, req_sig, req_exp, req_rm, frm, res_ready,
    input  req_ready, res_valid, res_id, res_sign, res_sig, res_exp, res_nx, res_of
  );

  modport slave (
    input  req_valid, req_sign, req_sig, req_exp, req_rm, frm, res_ready,
    output req_ready, res_valid, res_id, res_sign, res_sig, res_exp, res_nx, res_of
  );
endinterface

// File: rtl/fround_arbiter.sv
// rtl/fround_arbiter.sv - round-robin arbiter feeding one shared FRound rounding stage
module fround_arbiter #(
  parameter int n_req = 3,
  parameter int n_int = 32,
  parameter int n_exp = 8,
  parameter int n_sig = 23
) (
  input logic             clk,
  input logic             rst,
  fround_arbiter_if.slave bus
);
  localparam int id_w    = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int n_round = n_int - n_sig - 1;

  logic [id_w-1:0]  ptr;
  logic [id_w-1:0]  grant;
  logic             grant_found;
  logic             s1_accept;
  logic             s2_load;
  logic             transfer;
  logic [n_req-1:0] ready;

  logic             s1_valid;
  logic [id_w-1:0]  s1_id;
  logic             s1_sign;
  logic [n_int-1:0] s1_sig;
  logic [n_exp-1:0] s1_exp;
  logic [2:0]       s1_erm;

  logic [2:0]       rm_sel;
  logic [2:0]       erm_in;

  assign s2_load   = s1_valid && (!bus.res_valid || bus.res_ready);
  assign s1_accept = !s1_valid || s2_load;
  assign transfer  = grant_found && s1_accept;

  // Cyclic search upward from ptr; the first valid requester wins.
  always_comb begin
    logic [id_w:0] k;
    grant_found = 1'b0;
    grant       = '0;
    k           = '0;
    for (int i = 0; i < n_req; i++) begin
      k = {1'b0, ptr} + (id_w + 1)'(i);
      if (k >= (id_w + 1)'(n_req)) k = k - (id_w + 1)'(n_req);
      if (!grant_found && bus.req_valid[k[id_w-1:0]]) begin
        grant_found = 1'b1;
        grant       = k[id_w-1:0];
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!rst && transfer) ready[grant] = 1'b1;
  end
  assign bus.req_ready = ready;

  assign rm_sel = bus.req_rm[int'(grant)*3 +: 3];
  assign erm_in = (rm_sel == 3'b111) ? bus.frm : rm_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_sign  <= 1'b0;
      s1_sig   <= '0;
      s1_exp   <= '0;
      s1_erm   <= '0;
    end else if (transfer) begin
      ptr      <= (grant == id_w'(n_req - 1)) ? '0 : grant + 1'b1;
      s1_valid <= 1'b1;
      s1_id    <= grant;
      s1_sign  <= bus.req_sign[grant];
      s1_sig   <= bus.req_sig[int'(grant)*n_int +: n_int];
      s1_exp   <= bus.req_exp[int'(grant)*n_exp +: n_exp];
      s1_erm   <= erm_in;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  logic [n_sig:0]   m;
  logic             r_bit;
  logic             s_bit;
  logic             lsb;
  logic             up;
  logic [n_sig+1:0] r;
  logic [n_sig-1:0] sig_rnd;
  logic [n_exp-1:0] exp_rnd;
  logic             nx;
  logic             of;

  assign m     = s1_sig[n_int-1:n_round];
  assign r_bit = s1_sig[n_round-1];
  assign s_bit = |s1_sig[n_round-2:0];
  assign lsb   = s1_sig[n_round];

  // Reserved modes 101/110 fall into default and simply truncate.
  always_comb begin
    up = 1'b0;
    case (s1_erm)
      3'b000:  up = r_bit && (s_bit || lsb);
      3'b010:  up = s1_sign && (r_bit || s_bit);
      3'b011:  up = !s1_sign && (r_bit || s_bit);
      3'b100:  up = r_bit;
      default: up = 1'b0;
    endcase
  end

  assign r = {1'b0, m} + {{(n_sig + 1){1'b0}}, up};

  always_comb begin
    sig_rnd = r[n_sig-1:0];
    exp_rnd = s1_exp;
    if (r[n_sig+1]) begin
      sig_rnd = r[n_sig:1];
      exp_rnd = s1_exp + 1'b1;
    end
  end

  assign nx = r_bit || s_bit;
  assign of = (s1_exp != '1) && (exp_rnd == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_id    <= '0;
      bus.res_sign  <= 1'b0;
      bus.res_sig   <= '0;
      bus.res_exp   <= '0;
      bus.res_nx    <= 1'b0;
      bus.res_of    <= 1'b0;
    end else if (s2_load) begin
      bus.res_valid <= 1'b1;
      bus.res_id    <= s1_id;
      bus.res_sign  <= s1_sign;
      bus.res_sig   <= sig_rnd;
      bus.res_exp   <= exp_rnd;
      bus.res_nx    <= nx;
      bus.res_of    <= of;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end
endmodule

// File: doc/fround_arbiter.md
Name: fround_arbiter

Overview:
- Shares a single FRound rounding datapath between nReq FPU producers (e.g. FADD, FMUL, FCVT) using round-robin arbitration.
- Requesters present unrounded (sign, sig, exp, rm) over valid/ready. The block applies the dynamic rounding mode and returns the packed rounded result with a requester ID and IEEE flags.
- It is a 2-stage pipeline between the FPU execute units and the FP writeback/CSR flag logic.

Parameters:
- nReq, 3, number of requesters (2..8).
- nInt, 32, width of the unrounded significand; MSB is the implied 1.
- nExp, 8, exponent width.
- nSig, 23, stored fraction width. nRound = nInt-nSig-1 (must be >= 2).
- idW, derived = max(1, clog2(nReq)), width of the requester ID.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  nReq  per-requester valid.
- req_ready_o  out  nReq  per-requester ready; at most one bit set.
- req_sign_i  in  nReq  packed signs; requester k uses bit k.
- req_sig_i  in  nReq*nInt  packed significands; slice k is [k*nInt +: nInt].
- req_exp_i  in  nReq*nExp  packed exponents.
- req_rm_i  in  nReq*3  packed instruction rounding modes; 3'b111 = dynamic.
- frm_i  in  3  CSR frm, used when the request rm = 111.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer ready.
- res_id_o  out  idW  index of the originating requester.
- res_sign_o  out  1  sign, passed through unchanged.
- res_sig_o  out  nSig  rounded fraction.
- res_exp_o  out  nExp  rounded exponent.
- res_nx_o  out  1  inexact flag.
- res_of_o  out  1  overflow flag.

Behaviour:
- Handshake: a transfer occurs when valid && ready. A requester must hold its fields stable while valid && !ready. Output fields hold stable while res_valid_o && !res_ready_i.
- Stage S1 register: s1_valid, id, sign, sig, exp, effective rm (erm).
- Stage S2 is the output register set (res_*).
- s2_load = s1_valid && (!res_valid_o || res_ready_i).
- s1_accept = !s1_valid || s2_load.
- Arbitration, combinational:
  - Search requesters starting at pointer ptr, cyclically upward; grant the first with valid=1.
  - req_ready_o[g] = s1_accept for the granted g only; all other bits are 0.
  - No grant when s1_accept = 0.
  - On a transfer from g: ptr <= (g+1) mod nReq. ptr is unchanged when there is no transfer.
- Effective rm: erm = frm_i if req rm == 111, else req rm. frm_i is sampled at grant; later frm_i changes do not affect a captured request.
- S1 update: on a transfer, load the granted fields and set s1_valid=1. Else, if s2_load, clear s1_valid.
- S2 update: on s2_load, register the FRound outputs (sig, exp) computed from the S1 fields, plus id, sign and flags, and set res_valid_o=1. Else, if res_ready_i, clear res_valid_o.
- Latency and throughput: transfer at edge T -> res_valid_o high after edge T+1. Throughput is 1 result per cycle with no backpressure.
- Rounding (FRound semantics, instantiated with nInt/nExp/nSig):
  - Definitions: m = sig[nInt-1:nRound]; R = sig[nRound-1]; S = |sig[nRound-2:0]; lsb = sig[nRound].
  - Round-up decision by erm:
    - 000 (RNE): R&&(S||lsb).
    - 001 (RTZ): 0.
    - 010 (RDN): sign && (R||S).
    - 011 (RUP): !sign && (R||S).
    - 100 (RMM): R.
    - 101/110 (reserved): 0, i.e. truncate; no error is reported.
  - Result: r = {0,m} + up. If r[nSig+1]=1: sig_o = r[nSig:1], exp_o = exp+1 (nExp wrap). Else: sig_o = r[nSig-1:0], exp_o = exp.
- Flags:
  - res_nx_o = R||S, in every mode.
  - res_of_o = 1 iff exp != all-ones and exp_o == all-ones.
- Reset (async, mid-operation included):
  - s1_valid=0, res_valid_o=0, ptr=0.
  - res_id/sign/sig/exp/nx/of = 0.
  - In-flight requests are dropped.
  - req_ready_o is all 0 while rst_i is high.
- Simultaneous events: S1 may accept a new request in the same cycle it hands off to S2, and S2 may accept while the consumer takes the current result. Full back-to-back operation then has no bubbles.
- Backpressure: with res_ready_i=0, at most 2 requests are in flight (S1 and S2). After that, req_ready_o = 0.

Test Plan (defaults nInt=32, nExp=8, nSig=23):
1. RNE tie, odd lsb: req0 sig=0x80000180, exp=0x7F, rm=000 -> res_sig=0x000002, res_exp=0x7F, nx=1, of=0, id=0; res_valid_o high 2 edges after the transfer.
2. Carry into exponent and overflow: sig=0xFFFFFF80, exp=0x7F, RNE -> sig=0x000000, exp=0x80, of=0. Same with exp=0xFE -> exp=0xFF, of=1, nx=1.
3. Dynamic rm: rm=111, frm_i=001, sig=0x800001FF -> sig=0x000001 (truncated), nx=1. Change frm_i to 011 the cycle after grant -> result unchanged.
4. Round-robin: all 3 requesters valid continuously, res_ready_i=1 -> grants 0,1,2,0,1,2; res_id sequence 0,1,2,... one per cycle, no bubbles.
5. Backpressure: continuous requests with res_ready_i=0 for 6 cycles -> exactly 2 transfers. req_ready_o=0 afterwards; res_* stable. Releasing ready drains in order with no loss or duplication.
6. Reset mid-operation: assert rst_i while both stages are valid -> res_valid_o=0 and res_sig/exp/nx/of=0 immediately (async). After release, the first grant goes to requester 0.
